packed_pattern_gen: RTL
=======================

// Module: packed_pattern_gen
// PURPOSE
// - Parametrised generator of packed multi-dimensional frames (DIM_A x DIM_B x ELEMW) plus an int beat count.
// - Streams the frames over a valid/ready handshake. Replaces fixed constant-driver blocks in stimulus paths.
// - Patterns: constant, counting, walking-one, LFSR. Supports frame-limited or free-running operation.
// PARAMETERS
// DIM_A      3         outer dimension of frame
// DIM_B      2         middle dimension of frame
// ELEMW      3         bits per element; W = DIM_A*DIM_B*ELEMW (18 by default)
// NFRAMES    0         beats per run; 0 = unlimited (run until stop)
// LFSR_TAPS  'h20400   Galois feedback mask, W bits (x^18+x^11+1 at default W)
// PORTS
// clk        in   1        clock, all logic on rising edge
// rst        in   1        synchronous active-high reset
// start      in   1        begin a run; sampled only in IDLE
// stop       in   1        abort a run; sampled only in RUN
// mode       in   2        0 CONST, 1 COUNT, 2 WALK, 3 LFSR; latched on start
// seed       in   W        initial pattern; latched on start
// out_valid  out  1        frame is valid
// out_ready  in   1        consumer accepts frame
// frame      out  [DIM_A-1:0][DIM_B-1:0][ELEMW-1:0]  current pattern, flat bit order = W-1..0
// frame_cnt  out  int      accepted beats in current/last run
// busy       out  1        high in RUN
// done       out  1        one-cycle pulse when a run ends (limit reached or stop)
// BEHAVIOUR
// - Interface: one clock (clk); reset (rst) is synchronous and active-high.
// - Reset: state=IDLE. out_valid=0, frame='0, frame_cnt=0, busy=0, done=0.
// - Reset mid-run: same reset values on the next edge. No partial beat is counted.
// - FSM IDLE -> RUN on start. RUN -> DONE on limit or stop. DONE -> IDLE after 1 cycle.
// - IDLE + start (edge N):
//   - Latch mode and seed. frame_cnt<=0.
//   - frame<=first pattern. out_valid=1 and busy=1 from edge N.
//   - Latency start->valid is 1 cycle.
// - First pattern by mode:
//   - CONST, COUNT: seed.
//   - WALK: 1 (bit 0); seed ignored.
//   - LFSR: seed, or 1 if seed==0.
// - RUN, beat = out_valid & out_ready:
//   - frame_cnt++. frame_cnt saturates at 32'h7FFF_FFFF; never wraps negative.
//   - frame<=next pattern.
// - Next pattern by mode:
//   - CONST: unchanged.
//   - COUNT: frame+1 mod 2^W; wraps all-ones -> 0.
//   - WALK: rotate left 1; bit W-1 -> bit 0.
//   - LFSR: lsb ? (frame>>1)^LFSR_TAPS : frame>>1.
// - Stall: while out_valid & !out_ready, frame and frame_cnt hold stable. out_valid stays high.
// - Limit: if NFRAMES!=0 and a beat makes frame_cnt==NFRAMES:
//   - Next state DONE. out_valid=0 and busy=0 from that edge.
//   - frame holds the last accepted pattern (no advance).
// - stop in RUN:
//   - A beat in the same cycle counts.
//   - Next state DONE; out_valid=0 and busy=0. frame holds its value.
// - Simultaneous stop and limit beat: a single DONE; the beat counts once.
// - DONE: done=1 for exactly one cycle. start is ignored. frame_cnt holds the final count.
// - IDLE: start is accepted; stop is ignored. frame_cnt holds until the next start clears it.
// - start or stop outside its sampling state: no effect.
// - Mode or seed changes after start: no effect until the next run.
// - Outputs are registered; no combinational path from out_ready to out_valid.
// TESTING
// - Reset: hold rst 2 cycles, then idle -> out_valid=0, frame=0, frame_cnt=0, busy=0, done=0.
// - CONST, NFRAMES=4, seed=18'h2A5A5, ready=1:
//   - valid 1 cycle after start; 4 beats of 18'h2A5A5.
//   - frame_cnt=4; done pulses once; valid low after the 4th beat.
// - COUNT, seed=18'h3FFFE, ready=1:
//   - frames 3FFFE, 3FFFF, 00000, 00001 (wrap).
//   - ready=0 for 3 cycles mid-run -> frame and frame_cnt stable.
// - WALK, NFRAMES=0, 19 beats:
//   - bit 0 up to bit 17, then back to 18'h00001.
//   - stop with ready=1 -> beat counted, frame_cnt=19, done pulse.
// - LFSR, seed=0: first frame 18'h00001, second 18'h20400. rst mid-run -> all outputs at reset values.
// - Non-default params DIM_A=4, DIM_B=1, ELEMW=8 (W=32), COUNT: frames increment; frame[3] is the MSB byte.

Source files
------------

// File: rtl/packed_pattern_gen.sv
// Streams packed DIM_A x DIM_B x ELEMW frames (constant, counting, walking-one or LFSR)
// over a valid/ready handshake, optionally stopping after NFRAMES accepted beats.
module packed_pattern_gen #(
    parameter int DIM_A   = 3,
    parameter int DIM_B   = 2,
    parameter int ELEMW   = 3,
    parameter int NFRAMES = 0,
    parameter logic [DIM_A*DIM_B*ELEMW-1:0] LFSR_TAPS = 'h20400
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   stop,
    input  logic [1:0]                             mode,
    input  logic [DIM_A*DIM_B*ELEMW-1:0]           seed,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DIM_A-1:0][DIM_B-1:0][ELEMW-1:0] frame,
    output logic signed [31:0]                     frame_cnt,
    output logic                                   busy,
    output logic                                   done
);
    localparam int W = DIM_A * DIM_B * ELEMW;
    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [1:0] M_CONST = 2'd0;
    localparam logic [1:0] M_COUNT = 2'd1;
    localparam logic [1:0] M_WALK  = 2'd2;
    localparam logic [1:0] M_LFSR  = 2'd3;
    localparam logic signed [31:0] CNT_MAX = 32'sh7FFF_FFFF;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_mode;
    logic [W-1:0]       r_frame;
    logic signed [31:0] r_cnt;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic               w_beat;
    logic               w_limit;
    logic signed [31:0] w_cnt_inc;

    function automatic logic signed [31:0] sat_inc(input logic signed [31:0] c);
        return (c == CNT_MAX) ? c : c + 32'sd1;
    endfunction

    function automatic logic [W-1:0] first_pattern(input logic [1:0] m, input logic [W-1:0] s);
        case (m)
            M_WALK:  return ONE;
            M_LFSR:  return (s == '0) ? ONE : s;
            default: return s;
        endcase
    endfunction

    function automatic logic [W-1:0] next_pattern(input logic [1:0] m, input logic [W-1:0] f);
        case (m)
            M_COUNT: return f + ONE;
            M_WALK:  return {f[W-2:0], f[W-1]};
            M_LFSR:  return f[0] ? ((f >> 1) ^ LFSR_TAPS) : (f >> 1);
            default: return f;
        endcase
    endfunction

    always_comb begin
        w_beat    = r_valid & out_ready;
        w_cnt_inc = sat_inc(r_cnt);
        w_limit   = (NFRAMES != 0) && w_beat && (w_cnt_inc == NFRAMES);
        w_next    = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (stop || w_limit) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= M_CONST;
            r_frame <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == S_RUN);
            r_busy  <= (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
            if (r_state == S_IDLE && start) begin
                r_mode  <= mode;
                r_cnt   <= '0;
                r_frame <= first_pattern(mode, seed);
            end else if (r_state == S_RUN && w_beat) begin
                r_cnt <= w_cnt_inc;
                // Ending beats (limit or stop) leave the last accepted pattern on frame.
                if (w_next == S_RUN) r_frame <= next_pattern(r_mode, r_frame);
            end
        end
    end

    assign out_valid = r_valid;
    assign frame     = r_frame;
    assign frame_cnt = r_cnt;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule
